// File: rtl/meas_stream_receiver_pkg.sv
// -----------------------------------------------------------------------------
// meas_stream_receiver_pkg
//   Shared definitions for the measurement stream receiver:
//   - rx_state_t   : receiver FSM state encoding
//   - DEFAULT_FIFO_DEPTH : default number of FIFO entries
//   - LAST_W       : width of the last-flag field stored next to each word
//   - count_hit()  : "this word completes the transfer" test used by the FSM
// -----------------------------------------------------------------------------
package meas_stream_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_WAIT_LOW = 2'd2
  } rx_state_t;

  localparam int DEFAULT_FIFO_DEPTH = 512;
  localparam int LAST_W             = 1;

  // True when the word arriving now is the final one of a counted transfer.
  // A target of zero means "no count limit": only transfer_en falling ends it,
  // so the compare is suppressed even when rx_words wraps to all-ones.
  function automatic logic count_hit(input logic [31:0] words,
                                     input logic [31:0] target);
    return (target != 32'd0) && ((words + 32'd1) == target);
  endfunction

endpackage

// File: rtl/meas_rx_fifo.sv
// -----------------------------------------------------------------------------
// meas_rx_fifo
//   Synchronous first-word-fall-through FIFO with two ordered write slots.
//   Slot 0 is always the older word; slot 1 is written directly behind it in
//   the same cycle. The caller only asserts a slot when it has room for it.
//
// Ports:
//   CLK      in   clock
//   RESETN   in   synchronous active-low reset (flushes pointers)
//   wr_en    in   [1:0] write enables, slot 0 = older word
//   wr_data  in   [1:0][WIDTH-1:0] write data per slot
//   rd_en    in   pop the head entry (ignored when empty)
//   rd_data  out  head entry (valid while !empty)
//   full     out  no free entry
//   empty    out  no stored entry
//   count    out  number of stored entries
// -----------------------------------------------------------------------------
module meas_rx_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 512
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [1:0]                wr_en,
  input  logic [1:0][WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_slot1;
  logic [AW:0]      wr_step;

  // Slot 1 lands right after slot 0 when both are written, otherwise at the
  // current write pointer.
  assign wr_ptr_slot1 = wr_ptr + {{AW{1'b0}}, wr_en[0]};
  assign wr_step      = {{AW{1'b0}}, wr_en[0]} + {{AW{1'b0}}, wr_en[1]};

  // Pointers carry one extra bit so equal indices can be told apart as
  // full (MSBs differ) or empty (MSBs equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // Fall-through read: the head entry is visible without a read request.
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (wr_en[0]) begin
      mem[wr_ptr[AW-1:0]] <= wr_data[0];
    end
    if (wr_en[1]) begin
      mem[wr_ptr_slot1[AW-1:0]] <= wr_data[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_step;
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/meas_stream_receiver.sv
// -----------------------------------------------------------------------------
// meas_stream_receiver
//   PL-side receiver for the RO measurement core's transfer handshake.
//   Acknowledges a transfer request, captures the burst of result words into
//   a FWFT FIFO and replays them as an AXI4-Stream master with tlast on the
//   final word. Word count, overflow and short-transfer status are reported
//   to the register bank.
//
//   Each incoming word is parked in a one-entry hold register until the next
//   word (or the end of the transfer) reveals whether it is the last one, so
//   tlast can be attached at write time. A counted completion can therefore
//   push two words in one cycle (held word + final word); the FIFO has two
//   ordered write slots for that.
//
// Ports:
//   CLK              in   system clock
//   RESETN           in   synchronous active-low reset
//   transfer_en      in   RO core transfer request, high for the whole burst
//   transfer_active  out  acknowledge; words are accepted only while high
//   data_en          in   data_in qualifier
//   data_in          in   [DATA_W] result word
//   meas_readouts    in   [32] expected word count, latched at transfer start
//   m_axis_tdata     out  [DATA_W] stream data
//   m_axis_tvalid    out  stream valid
//   m_axis_tready    in   stream ready
//   m_axis_tlast     out  last word of transfer
//   rx_words         out  [32] words accepted in the current/last transfer
//   rx_overflow      out  sticky: a word was dropped on a full FIFO
//   rx_short         out  sticky: transfer ended before the expected count
//   rx_done          out  one-cycle pulse at transfer end
// -----------------------------------------------------------------------------
module meas_stream_receiver
  import meas_stream_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int DATA_W     = 32
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              transfer_en,
  output logic              transfer_active,
  input  logic              data_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [31:0]       meas_readouts,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [31:0]       rx_words,
  output logic              rx_overflow,
  output logic              rx_short,
  output logic              rx_done
);

  localparam int EW = DATA_W + LAST_W;          // stored entry: {last, data}
  localparam int CW = $clog2(FIFO_DEPTH) + 1;   // FIFO occupancy width

  rx_state_t         state;
  logic [31:0]       cnt_target;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

  logic              hit;
  logic              word_is_last;
  logic [1:0]        push_req;
  logic [1:0][EW-1:0] push_entry;
  logic [1:0]        push_ok;
  logic              push_drop;

  logic [1:0]        fifo_wr_en;
  logic              fifo_rd_en;
  logic [EW-1:0]     fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  // ---------------------------------------------------------------------------
  // Push request generation (ACTIVE only)
  // ---------------------------------------------------------------------------
  assign hit          = count_hit(rx_words, cnt_target);
  // A word arriving together with transfer_en low still counts and closes
  // the transfer, exactly like the word that reaches the target.
  assign word_is_last = hit || !transfer_en;

  always_comb begin
    push_req   = 2'b00;
    push_entry = '0;
    if (state == ST_ACTIVE) begin
      if (data_en) begin
        if (hold_valid) begin
          push_entry[0] = {1'b0, hold_data};
          push_req[0]   = 1'b1;
          if (word_is_last) begin
            push_entry[1] = {1'b1, data_in};
            push_req[1]   = 1'b1;
          end
        end else if (word_is_last) begin
          // Final word bypasses the hold register.
          push_entry[0] = {1'b1, data_in};
          push_req[0]   = 1'b1;
        end
      end else if (!transfer_en && hold_valid) begin
        // Early end: the parked word becomes the last one.
        push_entry[0] = {1'b1, hold_data};
        push_req[0]   = 1'b1;
      end
    end
  end

  // Room is judged on the occupancy at the start of the cycle; a pop in the
  // same cycle does not make room for a push. The older word always wins
  // the last free entry, so ordering is preserved when only one fits.
  assign push_ok[0] = !fifo_full;
  assign push_ok[1] = (fifo_count < CW'(FIFO_DEPTH - 1));
  assign fifo_wr_en = push_req & push_ok;
  assign push_drop  = |(push_req & ~push_ok);

  // ---------------------------------------------------------------------------
  // Receiver FSM with registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state           <= ST_IDLE;
      transfer_active <= 1'b0;
      cnt_target      <= 32'd0;
      rx_words        <= 32'd0;
      rx_overflow     <= 1'b0;
      rx_short        <= 1'b0;
      rx_done         <= 1'b0;
      hold_valid      <= 1'b0;
      hold_data       <= '0;
    end else begin
      rx_done <= 1'b0;
      if (push_drop) begin
        rx_overflow <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // A new request waits until the previous burst has fully drained.
          if (transfer_en && fifo_empty && !hold_valid) begin
            state           <= ST_ACTIVE;
            cnt_target      <= meas_readouts;
            rx_words        <= 32'd0;
            rx_overflow     <= 1'b0;
            rx_short        <= 1'b0;
            transfer_active <= 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (data_en) begin
            rx_words <= rx_words + 32'd1;
            if (word_is_last) begin
              hold_valid      <= 1'b0;
              rx_done         <= 1'b1;
              transfer_active <= 1'b0;
              // Reaching the count is never short, even if transfer_en fell
              // in the same cycle; an unlimited transfer is never short.
              rx_short        <= !hit && (cnt_target != 32'd0);
              state           <= hit ? ST_WAIT_LOW : ST_IDLE;
            end else begin
              hold_valid <= 1'b1;
              hold_data  <= data_in;
            end
          end else if (!transfer_en) begin
            hold_valid      <= 1'b0;
            rx_done         <= 1'b1;
            transfer_active <= 1'b0;
            rx_short        <= (cnt_target != 32'd0);
            state           <= ST_IDLE;
          end
        end

        ST_WAIT_LOW: begin
          // Counted transfer finished; ignore data until the core lets go.
          if (!transfer_en) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage and stream side
  // ---------------------------------------------------------------------------
  meas_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .wr_en   (fifo_wr_en),
    .wr_data (push_entry),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign fifo_rd_en    = m_axis_tready && !fifo_empty;
  assign m_axis_tvalid = !fifo_empty;
  // Head entry is masked while empty so the bus reads zero after reset
  // instead of whatever the storage happens to hold.
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_rd_data[DATA_W-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_rd_data[DATA_W];

endmodule

// File: doc/meas_stream_receiver.md
Name: meas_stream_receiver

Overview:
- PL-side receiving end of the measurement data handshake (transfer_en / transfer_active / data_en / data) driven by the RO measurement core.
- Acknowledges a transfer request, captures the burst of 32-bit result words into an on-chip FIFO and re-emits them as an AXI4-Stream master toward the PS DMA, tagging the final word with tlast.
- Reports word count, overflow and short-transfer status to the register bank.

Parameters:
- FIFO_DEPTH, 512, FIFO entries; power of two, minimum 4.
- DATA_W, 32, data width of data_in and m_axis_tdata.

Ports:
- CLK  in  1  system clock (sys_clk0 domain).
- RESETN  in  1  synchronous reset, active-low.
- transfer_en  in  1  RO core requests a transfer; held high for the whole burst.
- transfer_active  out  1  receiver acknowledges; words are accepted only while high.
- data_en  in  1  qualifies data_in for one cycle.
- data_in  in  DATA_W  result word.
- meas_readouts  in  32  expected word count; latched at transfer start.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of transfer.
- rx_words  out  32  words accepted in the current or last transfer.
- rx_overflow  out  1  sticky: a word was dropped because the FIFO was full.
- rx_short  out  1  sticky: transfer_en fell before meas_readouts words arrived.
- rx_done  out  1  one-cycle pulse at transfer end.

Behaviour:
- Reset (RESETN=0 at a CLK edge):
  - State goes to IDLE and the FIFO is flushed.
  - All outputs are 0.
  - Reset asserted mid-transfer or mid-stream discards all data; there is no partial tlast.
- States: IDLE, ACTIVE, WAIT_LOW.
- IDLE:
  - If transfer_en=1 and the FIFO is empty and the hold register is empty, go to ACTIVE on the next edge.
  - On that edge: latch cnt_target=meas_readouts, clear rx_words, rx_overflow and rx_short, and set transfer_active=1 (one-cycle ack latency).
  - transfer_en=1 while the FIFO is not empty: stay in IDLE; the request waits until the previous burst has drained.
- ACTIVE, handling of data_en=1:
  - rx_words increments.
  - The word is loaded into a one-entry hold register.
  - A previously held word is pushed to the FIFO with last=0.
- ACTIVE, completion by count:
  - When rx_words+1 == cnt_target on a data_en cycle, the new word is pushed directly with last=1 (it bypasses the hold register, and any held word is pushed with last=0 in the same cycle).
  - This happens two pushes per cycle at most.
  - Then rx_done pulses, transfer_active=0, and the state goes to WAIT_LOW.
- ACTIVE, completion by transfer_en=0 before count reached:
  - A held word, if present, is pushed with last=1.
  - rx_short=1, rx_done pulses, transfer_active=0, and the state goes to IDLE.
  - If zero words were received, no tlast is emitted.
- cnt_target=0: completion only by transfer_en falling; rx_short is not set in this case.
- WAIT_LOW: data_en is ignored. Go to IDLE when transfer_en=0.
- FIFO full on push:
  - The word is dropped and rx_overflow=1 (sticky until the next transfer start).
  - rx_words still counts the word.
  - A dropped last=1 word means tlast is lost; software uses rx_overflow.
- data_en while not ACTIVE: ignored, no status change.
- Simultaneous data_en=1 and transfer_en=0 in ACTIVE: the word is accepted and becomes the last word (last=1).
- Stream side:
  - First-word-fall-through FIFO: m_axis_tvalid = !empty, and m_axis_tdata/m_axis_tlast come from the FIFO head.
  - The entry is popped on tvalid&&tready.
  - tdata and tlast are stable while tvalid=1 and tready=0.
- FIFO storage: DATA_W+1 bits (data plus last). The write pointer and read pointer are log2(FIFO_DEPTH)+1 bits wide, with wrap detection by the MSB. Full and empty are registered-free combinational compares.
- rx_words wraps modulo 2^32 without flagging.

Decomposition:
- Shared header meas_rx_defs.vh:
  - State encodings ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_WAIT_LOW=2'd2.
  - Default FIFO_DEPTH.
  - Width of the last-flag field.
- Sub-module meas_rx_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH and ports wr_en, wr_data, rd_en, rd_data, full, empty. It needs two write ports, or the pushes are serialised through a small 2-entry input staging stage inside meas_stream_receiver.

Test Plan:
- meas_readouts=4, transfer_en high, 4 data_en words 0x11..0x14, tready=1 -> transfer_active rises 1 cycle after transfer_en; stream 0x11..0x14 with tlast only on 0x14; rx_words=4; rx_done single pulse; no flags.
- meas_readouts=8, only 3 words, then transfer_en drops -> 3 beats with tlast on the 3rd; rx_short=1; rx_words=3.
- FIFO_DEPTH=4, tready=0, meas_readouts=6, 6 words -> rx_overflow=1; exactly 4 entries stream once tready=1; rx_words=6.
- tready toggled 1/0 every cycle during a 16-word burst -> all 16 words in order; tdata stable during stalls; single tlast.
- RESETN=0 asserted after 2 of 4 words -> all outputs 0 next cycle, tvalid=0; a subsequent 4-word transfer completes normally.
- Second transfer_en raised while 3 words are still in the FIFO (tready=0) -> transfer_active stays 0 until the FIFO drains, then rises 1 cycle later.
